wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Write-back end of the MEM/WB pipeline register: consumes regwrite/memtoreg/memres/alures/writeregister,
//   selects the write-back value, and commits it into the 32-entry integer register file.
//   Serves the decode stage through two read ports with same-cycle write-through bypass. $0 is hardwired to zero.
//   Counts committed writes for debug and performance visibility.
// PARAMETERS
//   DATA_W   32  register and data width
//   ADDR_W   5   register index width; NREGS = 2**ADDR_W
//   CNT_W    16  width of the committed-write counter
// PORTS
//   clk                 in   1        pipeline clock; all state updates on posedge
//   reset               in   1        asynchronous, active-high; clears all state
//   regwrite_in         in   1        write enable from MEM/WB
//   memtoreg_in         in   1        1: write memres_in, 0: write alures_in
//   memres_in           in   DATA_W   load data from MEM/WB
//   alures_in           in   DATA_W   ALU result from MEM/WB
//   writeregister_in    in   ADDR_W   destination register index
//   readreg1_in         in   ADDR_W   decode read index, port 1 (rs)
//   readreg2_in         in   ADDR_W   decode read index, port 2 (rt)
//   readdata1_out       out  DATA_W   port 1 read data (combinational)
//   readdata2_out       out  DATA_W   port 2 read data (combinational)
//   wbdata_out          out  DATA_W   selected write-back value (combinational, for forwarding)
//   wbcount_out         out  CNT_W    number of committed writes since reset
// BEHAVIOUR
//   - Reset (async, assert at any time): all NREGS entries <= 0, counter <= 0; takes effect immediately,
//     no write commits in a cycle where reset is high. Outputs after reset: readdata* = 0, wbcount_out = 0.
//   - wbdata_out = memtoreg_in ? memres_in : alures_in; zero latency, independent of regwrite_in.
//   - Commit: effective write we = regwrite_in && (writeregister_in != 0). On posedge clk with we,
//     reg[writeregister_in] <= wbdata_out. Written value is architecturally visible one cycle later.
//   - Writes to $0 are discarded and do not increment the counter.
//   - Read port k: if readregk_in == 0 -> 0;
//     else if we && writeregister_in == readregk_in -> wbdata_out (bypass, same cycle);
//     else reg[readregk_in]. Both ports may address the same register; both bypass identically.
//   - Counter: wbcount_out increments by 1 on each clock edge with we; wraps 2**CNT_W-1 -> 0, no saturation.
//   - memtoreg_in, memres_in, alures_in are don't-care for state when regwrite_in = 0.
//   - No stall/flush inputs: upstream MEM/WB bubbles arrive as regwrite_in = 0.
// STRUCTURE
//   - Shared package (pipeline pkg): DATA_W, ADDR_W constants, ZERO_REG = 0, regidx_t and word_t typedefs,
//     shared with the other pipeline buffers and hazard/forwarding logic.
//   - One sub-module: regfile_array (NREGS x DATA_W storage, async clear, 1 write port, 2 raw read ports).
//     Top level holds the write-back mux, $0 masking, bypass compare and counter.
// TESTING
//   1. Assert reset mid-run after writes -> every register reads 0, wbcount_out = 0 while reset high and after.
//   2. regwrite=1, memtoreg=0, alures=0x0000_1234, wreg=5; next cycle read rs=5 -> 0x0000_1234, count=1.
//   3. regwrite=1, memtoreg=1, memres=0xDEAD_BEEF, alures=0x1, wreg=9, rs=rt=9 same cycle
//      -> both readdata = 0xDEAD_BEEF (bypass); after edge reg9 = 0xDEAD_BEEF.
//   4. regwrite=1, wreg=0, alures=0xFFFF_FFFF; rs=0 -> readdata1 = 0 same and next cycle; count unchanged.
//   5. regwrite=0, wreg=7, alures=0x55 -> reg7 unchanged, no bypass on rs=7, count unchanged, wbdata_out=0x55.
//   6. CNT_W=4: 17 consecutive writes to reg 3 -> wbcount_out sequence 1..15, 0, 1; reg3 holds last value.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Pipeline-wide constants and types shared by pipeline buffers, hazard and forwarding logic.
package wb_regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 2 ** ADDR_W;
  localparam int ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] regidx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/wb_regfile_array.sv
// Raw register storage: one write port, two unbypassed read ports, async clear.
// Latency: write visible one cycle after the edge; reads combinational; no backpressure.
module regfile_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects load/ALU result, commits to the register file, bypasses to decode reads, counts commits.
// Latency: wbdata and reads combinational, commit on next edge; no backpressure (bubbles arrive as regwrite_in=0).
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic [DATA_W-1:0] memres_in,
  input  logic [DATA_W-1:0] alures_in,
  input  logic [ADDR_W-1:0] writeregister_in,
  input  logic [ADDR_W-1:0] readreg1_in,
  input  logic [ADDR_W-1:0] readreg2_in,
  output logic [DATA_W-1:0] readdata1_out,
  output logic [DATA_W-1:0] readdata2_out,
  output logic [DATA_W-1:0] wbdata_out,
  output logic [CNT_W-1:0]  wbcount_out
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic              we;
  logic [DATA_W-1:0] raw1;
  logic [DATA_W-1:0] raw2;
  logic [CNT_W-1:0]  count;

  assign wbdata_out = memtoreg_in ? memres_in : alures_in;
  // $0 is never stored, so masking here keeps both the array and the counter clean.
  assign we = regwrite_in && (writeregister_in != ZERO_IDX);

  regfile_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .rst    (reset),
    .we     (we),
    .waddr  (writeregister_in),
    .wdata  (wbdata_out),
    .raddr1 (readreg1_in),
    .raddr2 (readreg2_in),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

  always_comb begin
    readdata1_out = raw1;
    if (readreg1_in == ZERO_IDX)                      readdata1_out = '0;
    else if (we && writeregister_in == readreg1_in)   readdata1_out = wbdata_out;
  end

  always_comb begin
    readdata2_out = raw2;
    if (readreg2_in == ZERO_IDX)                      readdata2_out = '0;
    else if (we && writeregister_in == readreg2_in)   readdata2_out = wbdata_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   count <= '0;
    else if (we) count <= count + 1'b1;
  end

  assign wbcount_out = count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for single-cycle behaviour plus reset and counter-wrap sequences.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        regwrite_in = 1'b0;
  logic        memtoreg_in = 1'b0;
  word_t       memres_in = '0;
  word_t       alures_in = '0;
  regidx_t     writeregister_in = '0;
  regidx_t     readreg1_in = '0;
  regidx_t     readreg2_in = '0;
  word_t       readdata1_out, readdata2_out, wbdata_out;
  logic [15:0] wbcount_out;
  word_t       rd1_s, rd2_s, wb_s;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .memres_in(memres_in), .alures_in(alures_in), .writeregister_in(writeregister_in),
    .readreg1_in(readreg1_in), .readreg2_in(readreg2_in),
    .readdata1_out(readdata1_out), .readdata2_out(readdata2_out),
    .wbdata_out(wbdata_out), .wbcount_out(wbcount_out)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .memres_in(memres_in), .alures_in(alures_in), .writeregister_in(writeregister_in),
    .readreg1_in(readreg1_in), .readreg2_in(readreg2_in),
    .readdata1_out(rd1_s), .readdata2_out(rd2_s),
    .wbdata_out(wb_s), .wbcount_out(cnt_s)
  );

  typedef struct {
    logic       rw;
    logic       mt;
    word_t      mem;
    word_t      alu;
    regidx_t    wreg;
    regidx_t    rs;
    regidx_t    rt;
    word_t      e_rd1;
    word_t      e_rd2;
    word_t      e_wb;
    int         e_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mt, input word_t mem, input word_t alu,
                       input regidx_t wreg, input regidx_t rs, input regidx_t rt);
    regwrite_in = rw; memtoreg_in = mt; memres_in = mem; alures_in = alu;
    writeregister_in = wreg; readreg1_in = rs; readreg2_in = rt;
  endtask

  initial begin
    //             rw    mt    memres        alures        wreg rs  rt  rd1           rd2           wb            cnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,        0,   0,  1,  32'h0,        32'h0,        32'h0,        0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        32'h0000_1234, 5,  5,  6,  32'h0000_1234, 32'h0,       32'h0000_1234, 0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        0,   5,  5,  32'h0000_1234, 32'h0000_1234, 32'h0,      1};
    vecs[3]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1,       9,   9,  9,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        0,   9,  5,  32'hDEAD_BEEF, 32'h0000_1234, 32'h0,      2};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 0,  0,  9,  32'h0,        32'hDEAD_BEEF, 32'hFFFF_FFFF, 2};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        0,   0,  0,  32'h0,        32'h0,        32'h0,        2};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h55,       7,   7,  5,  32'h0,        32'h0000_1234, 32'h55,      2};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,        0,   7,  9,  32'h0,        32'hDEAD_BEEF, 32'h0,       2};
    vecs[9]  = '{1'b1, 1'b0, 32'h66,       32'h77,       7,   7,  7,  32'h77,       32'h77,       32'h77,       2};
    vecs[10] = '{1'b1, 1'b1, 32'h88,       32'h99,       7,   7,  5,  32'h88,       32'h0000_1234, 32'h88,      3};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        0,   7,  0,  32'h88,       32'h0,        32'h0,        4};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        32'hA5A5_0001, 31, 30, 31, 32'h0,        32'hA5A5_0001, 32'hA5A5_0001, 4};
    vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        0,   31, 1,  32'hA5A5_0001, 32'h0,       32'h0,        5};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rw, vecs[i].mt, vecs[i].mem, vecs[i].alu, vecs[i].wreg, vecs[i].rs, vecs[i].rt);
      #1;
      chk($sformatf("v%0d rd1", i), readdata1_out, vecs[i].e_rd1);
      chk($sformatf("v%0d rd2", i), readdata2_out, vecs[i].e_rd2);
      chk($sformatf("v%0d wb", i), wbdata_out, vecs[i].e_wb);
      chk($sformatf("v%0d cnt", i), word_t'(wbcount_out), word_t'(vecs[i].e_cnt));
    end

    // Async reset mid-cycle: clears immediately, and a write held active across an edge must not commit.
    @(posedge clk);
    #2;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 0, 31, 9);
    reset = 1'b1;
    #1;
    chk("rst_async rd1", readdata1_out, 32'h0);
    chk("rst_async rd2", readdata2_out, 32'h0);
    chk("rst_async cnt", word_t'(wbcount_out), 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'hCAFE_0005, 5, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_hold cnt", word_t'(wbcount_out), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    reset = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      readreg1_in = regidx_t'(r);
      readreg2_in = regidx_t'(NREGS - 1 - r);
      #1;
      chk($sformatf("post_rst r%0d", r), readdata1_out, 32'h0);
      chk($sformatf("post_rst rt r%0d", NREGS - 1 - r), readdata2_out, 32'h0);
    end
    chk("post_rst cnt", word_t'(wbcount_out), 32'h0);

    // 17 consecutive writes to reg 3: 4-bit counter runs 1..15, 0, 1.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 32'h100 + word_t'(k), 3, 0, 0);
      @(posedge clk);
      #1;
      chk($sformatf("wrap cnt k%0d", k), word_t'(cnt_s), word_t'((k + 1) % 16));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 0, 3, 3);
    #1;
    chk("wrap reg3 dut4", rd1_s, 32'h110);
    chk("wrap reg3 dut", readdata2_out, 32'h110);
    chk("wrap cnt16", word_t'(wbcount_out), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
